// File: rtl/k12a_sequencer.sv
// K12A control sequencer: holds the control state, instruction register, skip
// flag and retired-instruction counter, gated by free-run or single-step enable.
package k12a_sequencer_pkg;
  typedef enum logic [2:0] {
    STATE_FETCH1 = 3'd0,
    STATE_FETCH2 = 3'd1,
    STATE_FETCH3 = 3'd2,
    STATE_EXEC   = 3'd3,
    STATE_HALT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SKIP_SEL_0                  = 2'd0,
    SKIP_SEL_CONDITION          = 2'd1,
    SKIP_SEL_CONDITION_INVERTED = 2'd2
  } skip_sel_t;
endpackage

// Handshake: step_req/step_ack is a 4-phase pair. A request seen with
// step_ack=0 and run=0 yields exactly one enabled cycle and raises step_ack;
// step_ack drops on the first edge after step_req is released.
module k12a_sequencer
  import k12a_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  state_t      next_state,
  input  logic [7:0]  data_bus,
  input  logic        inst_high_store,
  input  logic        inst_low_store,
  input  skip_sel_t   skip_sel,
  input  logic        skip_store,
  input  logic        alu_condition,
  input  logic        run,
  input  logic        step_req,
  output logic        step_ack,
  input  logic        resume,
  output logic        cycle_en,
  output state_t      state,
  output logic [15:0] inst,
  output logic        skip,
  output logic        halted,
  output logic [15:0] instret
);

  state_t      state_q, state_d;
  logic [15:0] inst_q, inst_d;
  logic        skip_q, skip_d;
  logic [15:0] instret_q, instret_d;
  logic        step_ack_q, step_ack_d;

  assign cycle_en = run | (step_req & ~step_ack_q);

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    skip_d     = skip_q;
    instret_d  = instret_q;
    step_ack_d = step_ack_q;

    if (cycle_en) begin
      if (state_q == STATE_HALT && resume) state_d = STATE_FETCH1;
      else                                 state_d = next_state;

      if (inst_high_store) inst_d[15:8] = data_bus;
      if (inst_low_store)  inst_d[7:0]  = data_bus;

      if (skip_store) begin
        case (skip_sel)
          SKIP_SEL_0:                  skip_d = 1'b0;
          SKIP_SEL_CONDITION:          skip_d = alu_condition;
          SKIP_SEL_CONDITION_INVERTED: skip_d = ~alu_condition;
          default:                     skip_d = skip_q;
        endcase
      end

      if (state_q == STATE_EXEC) instret_d = instret_q + 16'd1;
    end

    // The acknowledge runs regardless of cycle_en so the handshake can close.
    if (!step_ack_q) step_ack_d = step_req & ~run;
    else if (!step_req) step_ack_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= STATE_FETCH1;
      inst_q     <= 16'h0000;
      skip_q     <= 1'b0;
      instret_q  <= 16'h0000;
      step_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      skip_q     <= skip_d;
      instret_q  <= instret_d;
      step_ack_q <= step_ack_d;
    end
  end

  assign state    = state_q;
  assign inst     = inst_q;
  assign skip     = skip_q;
  assign instret  = instret_q;
  assign step_ack = step_ack_q;
  assign halted   = (state_q == STATE_HALT);

endmodule

// File: tb/tb_k12a_sequencer.sv
// Self-checking bench for k12a_sequencer: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the sequencer rules.
module tb_k12a_sequencer;
  import k12a_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  state_t      next_state;
  logic [7:0]  data_bus;
  logic        inst_high_store, inst_low_store;
  skip_sel_t   skip_sel;
  logic        skip_store, alu_condition, run, step_req, resume;
  logic        step_ack, cycle_en, skip, halted;
  state_t      state;
  logic [15:0] inst, instret;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model
  int          m_state;
  logic [15:0] m_inst;
  logic        m_skip;
  int          m_instret;
  logic        m_ack;

  int en_pulses;
  int advances;

  k12a_sequencer dut (
    .clock(clock), .reset_n(reset_n), .next_state(next_state),
    .data_bus(data_bus), .inst_high_store(inst_high_store),
    .inst_low_store(inst_low_store), .skip_sel(skip_sel),
    .skip_store(skip_store), .alu_condition(alu_condition), .run(run),
    .step_req(step_req), .step_ack(step_ack), .resume(resume),
    .cycle_en(cycle_en), .state(state), .inst(inst), .skip(skip),
    .halted(halted), .instret(instret)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_inst    = 16'h0000;
    m_skip    = 1'b0;
    m_instret = 0;
    m_ack     = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".state"},    32'(state),    32'(m_state));
    check({tag, ".inst"},     32'(inst),     32'(m_inst));
    check({tag, ".skip"},     32'(skip),     32'(m_skip));
    check({tag, ".instret"},  32'(instret),  32'(m_instret));
    check({tag, ".step_ack"}, 32'(step_ack), 32'(m_ack));
    check({tag, ".halted"},   32'(halted),   32'(m_state == 4));
  endtask

  // One clock: check enable, predict the edge, then compare after the edge.
  task automatic tick(input string tag);
    logic en;
    int   prev;
    #1;
    en = run || (step_req && !m_ack);
    check({tag, ".cycle_en"}, 32'(cycle_en), 32'(en));
    if (cycle_en) en_pulses++;
    prev = m_state;
    if (en) begin
      if (m_state == 4 && resume) m_state = 0;
      else                        m_state = int'(next_state);
      if (inst_high_store) m_inst = {data_bus, m_inst[7:0]};
      if (inst_low_store)  m_inst = {m_inst[15:8], data_bus};
      if (skip_store) begin
        if (skip_sel == SKIP_SEL_0)              m_skip = 1'b0;
        else if (skip_sel == SKIP_SEL_CONDITION) m_skip = alu_condition;
        else                                     m_skip = !alu_condition;
      end
      if (prev == 3) m_instret = (m_instret + 1) % 65536;
    end
    if (!m_ack) m_ack = step_req && !run;
    else        m_ack = step_req;
    if (m_state != prev) advances++;
    @(posedge clock);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle();
    next_state      = STATE_FETCH1;
    data_bus        = 8'h00;
    inst_high_store = 1'b0;
    inst_low_store  = 1'b0;
    skip_sel        = SKIP_SEL_0;
    skip_store      = 1'b0;
    alu_condition   = 1'b0;
    resume          = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clock);
    #3;
    reset_n = 1'b1;
  endtask

  task automatic drive_state(input state_t ns);
    idle();
    next_state = ns;
  endtask

  initial begin
    reset_n  = 1'b0;
    run      = 1'b1;
    step_req = 1'b0;
    idle();
    model_reset();
    en_pulses = 0;
    advances  = 0;
    #12;
    check_outputs("por");
    reset_n = 1'b1;

    // Instruction fetch through to EXEC
    drive_state(STATE_FETCH2); data_bus = 8'hA5; inst_high_store = 1'b1; tick("fetch1");
    drive_state(STATE_FETCH3); data_bus = 8'h3C; inst_low_store  = 1'b1; tick("fetch2");
    drive_state(STATE_EXEC);   tick("fetch3");
    drive_state(STATE_FETCH1); tick("exec");
    check("req018.inst", 32'(inst), 32'h0000A53C);
    check("req018.instret", 32'(instret), 32'd1);

    // Skip flag selects
    drive_state(STATE_FETCH1); skip_store = 1'b1;
    skip_sel = SKIP_SEL_CONDITION_INVERTED; alu_condition = 1'b0; tick("skip_inv");
    check("req019.skip_set", 32'(skip), 32'd1);
    drive_state(STATE_FETCH1); skip_store = 1'b1; skip_sel = SKIP_SEL_0; tick("skip_zero");
    check("req019.skip_clr", 32'(skip), 32'd0);
    drive_state(STATE_FETCH2); skip_store = 1'b1;
    skip_sel = SKIP_SEL_CONDITION; alu_condition = 1'b1; tick("skip_cond");

    // Single-step: three complete handshakes, each advancing to a new state
    run = 1'b0;
    drive_state(STATE_FETCH2);
    tick("step_idle");
    en_pulses = 0;
    advances  = 0;
    for (int h = 0; h < 3; h++) begin
      drive_state((m_state == 2) ? STATE_FETCH1 : STATE_FETCH3);
      step_req = 1'b1;
      for (int k = 0; k < 3; k++) tick("step_hold");
      step_req = 1'b0;
      tick("step_rel");
      tick("step_gap");
    end
    check("req020.pulses3", 32'(en_pulses), 32'd3);
    check("req020.adv3", 32'(advances), 32'd3);

    en_pulses = 0;
    advances  = 0;
    drive_state((m_state == 2) ? STATE_FETCH1 : STATE_FETCH3);
    step_req = 1'b1;
    for (int k = 0; k < 10; k++) tick("step_long");
    check("req020.pulses1", 32'(en_pulses), 32'd1);
    check("req020.adv1", 32'(advances), 32'd1);
    // Run rises while acknowledged: ack must persist until req drops
    run = 1'b1;
    drive_state(STATE_FETCH2);
    tick("run_mid_ack");
    check("req013.ack_held", 32'(step_ack), 32'd1);
    step_req = 1'b0;
    tick("run_ack_drop");

    // Halt and resume
    drive_state(STATE_HALT); tick("halt_enter");
    for (int k = 0; k < 20; k++) begin
      drive_state(STATE_HALT);
      tick("halt_hold");
    end
    check("req021.halted", 32'(halted), 32'd1);
    drive_state(STATE_FETCH3); resume = 1'b1; tick("resume");
    check("req021.state", 32'(state), 32'(STATE_FETCH1));
    check("req021.unhalted", 32'(halted), 32'd0);
    drive_state(STATE_FETCH2); resume = 1'b1; tick("resume_noeffect");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      next_state      = state_t'($urandom_range(0, 4));
      data_bus        = 8'($urandom_range(0, 255));
      inst_high_store = 1'($urandom_range(0, 1));
      inst_low_store  = 1'($urandom_range(0, 1));
      skip_sel        = skip_sel_t'($urandom_range(0, 2));
      skip_store      = 1'($urandom_range(0, 1));
      alu_condition   = 1'($urandom_range(0, 1));
      resume          = ($urandom_range(0, 3) == 0);
      run             = ($urandom_range(0, 2) == 0);
      step_req        = 1'($urandom_range(0, 1));
      tick("rand");
    end

    // Counter wrap
    run = 1'b1;
    step_req = 1'b0;
    do_reset();
    drive_state(STATE_EXEC);
    tick("to_exec");
    for (int k = 0; k < 65535; k++) begin
      @(posedge clock);
      m_instret = (m_instret + 1) % 65536;
    end
    #1;
    check("req022.full", 32'(instret), 32'h0000FFFF);
    check("req022.model_full", 32'(instret), 32'(m_instret));
    tick("wrap");
    check("req022.wrap", 32'(instret), 32'h00000000);

    // Asynchronous reset mid-EXEC with acknowledge high
    drive_state(STATE_FETCH2); tick("pre_f2");
    drive_state(STATE_FETCH3); tick("pre_f3");
    run = 1'b0;
    step_req = 1'b1;
    drive_state(STATE_EXEC);
    data_bus = 8'h5A; inst_high_store = 1'b1;
    skip_store = 1'b1; skip_sel = SKIP_SEL_CONDITION_INVERTED;
    tick("pre_exec");
    check("req023.pre_ack", 32'(step_ack), 32'd1);
    check("req023.pre_state", 32'(state), 32'(STATE_EXEC));
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    check("req023.state", 32'(state), 32'(STATE_FETCH1));
    check("req023.ack", 32'(step_ack), 32'd0);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    step_req = 1'b0;
    run = 1'b1;
    drive_state(STATE_FETCH2);
    tick("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
